if_id_queue: RTL and testbench

IF_ID_QUEUE -- requirements
Module: if_id_queue

---
 rtl/cpuDefine.sv | 16 +
 rtl/if_id_queue.sv | 86 ++++++++
 tb/tb_if_id_queue.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpuDefine.sv
// Shared CPU types: instruction word, datapath word, and the IF/ID queue entry.
package cpuDefine;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned IFQ_DEPTH = 4;

   typedef logic [31:0]     Instr;
   typedef logic [XLEN-1:0] DType;

   typedef struct packed {
      DType pc;
      Instr instr;
      logic excp;
   } IfqEntry;

endpackage

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: circular buffer of fetched instructions feeding decode.
// Optional zero-latency empty-queue bypass enabled by defining IFQ_BYPASS_EN.
module if_id_queue
   import cpuDefine::*;
#(
   parameter int unsigned DEPTH = IFQ_DEPTH
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic in_valid,
   output logic in_ready,
   input  DType in_pc,
   input  Instr in_instr,
   input  logic in_excp,
   output logic out_valid,
   input  logic out_ready,
   output DType out_pc,
   output Instr out_instr,
   output logic out_excp
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   IfqEntry            mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   IfqEntry            head;
   logic               push;
   logic               pop;
   logic               bypass_take;

   // Handshake decode and head presentation (storage head, or input when bypassing).
   always_comb begin
      head        = mem[rd_ptr];
      in_ready    = (count != CNT_W'(DEPTH));
      out_valid   = (count != '0);
      out_pc      = head.pc;
      out_instr   = head.instr;
      out_excp    = head.excp;
      bypass_take = 1'b0;
`ifdef IFQ_BYPASS_EN
      if ((count == '0) && in_valid && !flush) begin
         out_valid   = 1'b1;
         out_pc      = in_pc;
         out_instr   = in_instr;
         out_excp    = in_excp;
         bypass_take = out_ready;
      end
`endif
      push = in_valid && in_ready && !flush && !bypass_take;
      pop  = (count != '0) && out_ready && !flush;
   end

   // Pointer, count and storage update; flush discards everything, including this cycle's beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= '{pc: in_pc, instr: in_instr, excp: in_excp};
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (default 4-entry build).
module tb_if_id_queue;
   import cpuDefine::*;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   logic in_valid;
   logic in_ready;
   DType in_pc;
   Instr in_instr;
   logic in_excp;
   logic out_valid;
   logic out_ready;
   DType out_pc;
   Instr out_instr;
   logic out_excp;

   int checks   = 0;
   int failures = 0;

   if_id_queue #(.DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .in_excp   (in_excp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_instr (out_instr),
      .out_excp  (out_excp)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid  = 1'b0;
      in_pc     = '0;
      in_instr  = '0;
      in_excp   = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      #13;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
      checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
      checks++; if (out_excp !== 1'b0) begin failures++; $display("FAIL reset_out_excp got=%b exp=0", out_excp); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_single();
      in_valid = 1'b1; in_pc = 32'h1c000000; in_instr = 32'h02800c21; out_ready = 1'b1;
      #1;
`ifdef IFQ_BYPASS_EN
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_bypass_valid got=%b exp=1", out_valid); end
      checks++; if (out_pc !== 32'h1c000000) begin failures++; $display("FAIL single_bypass_pc got=%h exp=1c000000", out_pc); end
      step();
      in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_bypass_not_stored got=%b exp=0", out_valid); end
`else
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_no_comb_path got=%b exp=0", out_valid); end
      step();
      in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
      checks++; if (out_pc !== 32'h1c000000) begin failures++; $display("FAIL single_pc got=%h exp=1c000000", out_pc); end
      checks++; if (out_instr !== 32'h02800c21) begin failures++; $display("FAIL single_instr got=%h exp=02800c21", out_instr); end
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_popped got=%b exp=0", out_valid); end
`endif
      idle();
      step();
   endtask

   task automatic test_fill();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_pc = 32'h1c000100 + 32'(4 * i); in_instr = 32'(i + 16);
         step();
      end
      in_valid = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
      in_valid = 1'b1; in_pc = 32'hdeadbeef; in_instr = 32'hffffffff;
      step();
      in_valid = 1'b0;
      checks++; if (dut.count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", dut.count); end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fill_pop_valid[%0d] got=%b exp=1", i, out_valid); end
         checks++; if (out_pc !== 32'h1c000100 + 32'(4 * i)) begin failures++; $display("FAIL fill_pop_pc[%0d] got=%h exp=%h", i, out_pc, 32'h1c000100 + 32'(4 * i)); end
         step();
      end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fill_drained got=%b exp=0", out_valid); end
      idle();
      step();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_pc = 32'h00002000 + 32'(4 * i); in_instr = 32'(i);
         step();
      end
      out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         in_valid = 1'b1; in_pc = 32'h00002000 + 32'(4 * (k + 2)); in_instr = 32'(k + 2);
         #1;
         checks++; if (out_pc !== 32'h00002000 + 32'(4 * k)) begin failures++; $display("FAIL b2b_pc[%0d] got=%h exp=%h", k, out_pc, 32'h00002000 + 32'(4 * k)); end
         checks++; if (out_instr !== 32'(k)) begin failures++; $display("FAIL b2b_instr[%0d] got=%h exp=%h", k, out_instr, 32'(k)); end
         step();
         checks++; if (dut.count !== 3'd2) begin failures++; $display("FAIL b2b_count[%0d] got=%0d exp=2", k, dut.count); end
      end
      in_valid = 1'b0;
      for (int k = 20; k < 22; k++) begin
         #1;
         checks++; if (out_pc !== 32'h00002000 + 32'(4 * k)) begin failures++; $display("FAIL b2b_drain_pc[%0d] got=%h exp=%h", k, out_pc, 32'h00002000 + 32'(4 * k)); end
         step();
      end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", out_valid); end
      idle();
      step();
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_pc = 32'h00003000 + 32'(4 * i); in_instr = 32'(i);
         step();
      end
      flush = 1'b1; in_valid = 1'b1; in_pc = 32'h00003100; out_ready = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
      checks++; if (dut.count !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", dut.count); end
      in_valid = 1'b1; in_pc = 32'h00004000; in_instr = 32'h00000aaa;
      step();
      in_valid = 1'b0;
      #1;
      checks++; if (out_pc !== 32'h00004000) begin failures++; $display("FAIL flush_next_pc got=%h exp=00004000", out_pc); end
      out_ready = 1'b1;
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_only_one got=%b exp=0", out_valid); end
      idle();
      step();
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_pc = 32'h00005000 + 32'(4 * i); in_instr = 32'h11110000 + 32'(i);
         step();
      end
      in_valid = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL arst_out_pc got=%h exp=0", out_pc); end
      checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL arst_out_instr got=%h exp=0", out_instr); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL arst_in_ready got=%b exp=1", in_ready); end
      #1;
      rst = 1'b0;
      in_valid = 1'b1; in_pc = 32'h00005800; in_instr = 32'h22220000;
      step();
      in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL arst_first_push_valid got=%b exp=1", out_valid); end
      checks++; if (out_pc !== 32'h00005800) begin failures++; $display("FAIL arst_first_push_pc got=%h exp=00005800", out_pc); end
      out_ready = 1'b1;
      step();
      idle();
      step();
   endtask

   task automatic test_excp();
      out_ready = 1'b0;
      in_valid = 1'b1; in_pc = 32'h00006000; in_instr = 32'h0; in_excp = 1'b1;
      step();
      in_valid = 1'b0; in_excp = 1'b0; in_pc = 32'h0000ffff; in_instr = 32'hffffffff;
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL excp_valid[%0d] got=%b exp=1", c, out_valid); end
         checks++; if (out_excp !== 1'b1) begin failures++; $display("FAIL excp_tag[%0d] got=%b exp=1", c, out_excp); end
         checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL excp_instr[%0d] got=%h exp=0", c, out_instr); end
         checks++; if (out_pc !== 32'h00006000) begin failures++; $display("FAIL excp_pc[%0d] got=%h exp=00006000", c, out_pc); end
         if (c < 3) step();
      end
      out_ready = 1'b1;
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL excp_popped got=%b exp=0", out_valid); end
      idle();
      step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_excp();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
